// File: rtl/mdu_seq_if.sv
// Execute-stage <-> RV32M multiply/divide unit signal bundle.
// The slave modport is the MDU view; the master modport is the pipeline view.
interface mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            DD_mdu_valid_i;
  logic [7:0]      DD_mdu_op_i;
  logic [XLEN-1:0] DD_rs1_data_i;
  logic [XLEN-1:0] DD_rs2_data_i;
  logic            flush_i;
  logic            E_mdu_stall_o;
  logic            E_mdu_valid_o;
  logic [XLEN-1:0] E_mdu_result_o;

  modport slave (
    input  DD_mdu_valid_i, DD_mdu_op_i, DD_rs1_data_i, DD_rs2_data_i, flush_i,
    output E_mdu_stall_o, E_mdu_valid_o, E_mdu_result_o
  );

  modport master (
    output DD_mdu_valid_i, DD_mdu_op_i, DD_rs1_data_i, DD_rs2_data_i, flush_i,
    input  E_mdu_stall_o, E_mdu_valid_o, E_mdu_result_o
  );
endinterface

// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional MDU_FAST_MUL_EN: all multiplies done in one cycle by a combinational multiplier.
module mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  mdu_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_op;
  logic              r_neg_q, r_neg_r;
  logic [XLEN-1:0]   r_b, r_hi, r_lo, r_result;

  logic              w_accept, w_is_mul, w_is_div, w_s1_signed, w_s2_signed;
  logic              w_neg1, w_neg2, w_div0, w_ovf, w_fast, w_valid, w_stall;
  logic [XLEN-1:0]   w_abs1, w_abs2, w_special_res, w_fast_res;

  logic [XLEN-1:0]   w_rs1, w_rs2;
  logic [7:0]        w_op;

  assign w_rs1 = bus.DD_rs1_data_i;
  assign w_rs2 = bus.DD_rs2_data_i;
  assign w_op  = bus.DD_mdu_op_i;

  // Decode of the incoming op; only meaningful in the acceptance cycle.
  assign w_accept    = (r_state == S_IDLE) & bus.DD_mdu_valid_i & ~bus.flush_i;
  assign w_is_mul    = |w_op[3:0];
  assign w_is_div    = |w_op[7:4];
  assign w_s1_signed = w_op[0] | w_op[1] | w_op[2] | w_op[4] | w_op[6];
  assign w_s2_signed = w_op[0] | w_op[1] | w_op[4] | w_op[6];
  assign w_neg1      = w_s1_signed & w_rs1[XLEN-1];
  assign w_neg2      = w_s2_signed & w_rs2[XLEN-1];
  assign w_abs1      = w_neg1 ? (~w_rs1 + 1'b1) : w_rs1;
  assign w_abs2      = w_neg2 ? (~w_rs2 + 1'b1) : w_rs2;
  assign w_div0      = w_is_div & (w_rs2 == '0);
  assign w_ovf       = (w_op[4] | w_op[6]) & (w_rs1 == MIN_NEG) & (w_rs2 == '1);

  always_comb begin
    w_special_res = '0;
    if (w_div0)
      w_special_res = (w_op[4] | w_op[5]) ? '1 : w_rs1;
    else if (w_ovf)
      w_special_res = w_op[4] ? MIN_NEG : '0;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_a, w_fast_b, w_fast_prod;
  // Sign-extending to full width makes the low 2*XLEN product bits correct for every sign mix.
  assign w_fast_a    = {{XLEN{w_neg1}}, w_rs1};
  assign w_fast_b    = {{XLEN{w_neg2}}, w_rs2};
  assign w_fast_prod = w_fast_a * w_fast_b;
  assign w_fast      = w_is_mul;
  assign w_fast_res  = w_op[0] ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
`else
  assign w_fast      = 1'b0;
  assign w_fast_res  = '0;
`endif

  // One iteration step; r_hi/r_lo hold product halves or remainder/quotient.
  logic [XLEN:0]     w_mul_sum, w_div_sh;
  logic [XLEN-1:0]   w_div_diff, w_hi_n, w_lo_n, w_quo, w_rem, w_calc_res;
  logic              w_div_ge, w_r_is_div;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;

  assign w_r_is_div = |r_op[7:4];
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_div_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_b});
  assign w_div_diff = w_div_sh[XLEN-1:0] - r_b;
  assign w_hi_n     = w_r_is_div ? (w_div_ge ? w_div_diff : w_div_sh[XLEN-1:0])
                                 : w_mul_sum[XLEN:1];
  assign w_lo_n     = w_r_is_div ? {r_lo[XLEN-2:0], w_div_ge}
                                 : {w_mul_sum[0], r_lo[XLEN-1:1]};
  assign w_prod     = {w_hi_n, w_lo_n};
  assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo      = r_neg_q ? (~w_lo_n + 1'b1) : w_lo_n;
  assign w_rem      = r_neg_r ? (~w_hi_n + 1'b1) : w_hi_n;

  always_comb begin
    w_calc_res = w_rem;
    if (r_op[0])
      w_calc_res = w_prod_fix[XLEN-1:0];
    else if (|r_op[3:1])
      w_calc_res = w_prod_fix[2*XLEN-1:XLEN];
    else if (|r_op[5:4])
      w_calc_res = w_quo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_valid      = 1'b0;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept)
                w_state_next = (w_div0 | w_ovf | w_fast) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == CNT_LAST)
                w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (bus.flush_i)
      w_state_next = S_IDLE;
    w_valid = (r_state == S_DONE) & ~bus.flush_i;
    // Stall drops during reset and in the result cycle so the pipeline can advance.
    w_stall = rst_n & bus.DD_mdu_valid_i & (r_state != S_DONE) & ~bus.flush_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op     <= w_op;
      r_neg_q  <= w_neg1 ^ w_neg2;
      r_neg_r  <= w_neg1;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_b      <= w_is_mul ? w_abs1 : w_abs2;
      r_lo     <= w_is_mul ? w_abs2 : w_abs1;
      r_result <= (w_div0 | w_ovf) ? w_special_res : (w_fast ? w_fast_res : '0);
    end else if (r_state == S_CALC) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CNT_LAST)
        r_result <= w_calc_res;
    end
  end

  assign bus.E_mdu_stall_o  = w_stall;
  assign bus.E_mdu_valid_o  = w_valid;
  assign bus.E_mdu_result_o = w_valid ? r_result : '0;

endmodule

// File: tb/tb_mdu_seq.sv
// Randomized scoreboard bench for mdu_seq: driver queues expected results from an
// arithmetic reference model; a monitor checks each result strobe and its latency.
module tb_mdu_seq;

  localparam logic [7:0] OP_MUL = 8'h01, OP_MULH = 8'h02, OP_MULHSU = 8'h04, OP_MULHU = 8'h08;
  localparam logic [7:0] OP_DIV = 8'h10, OP_DIVU = 8'h20, OP_REM = 8'h40, OP_REMU = 8'h80;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;

  typedef struct {
    logic [31:0] res;
    longint      t;
    int          lat;
    logic [7:0]  op;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;

  mdu_seq_if #(.XLEN(32)) bus();

  mdu_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference: plain 64-bit arithmetic with the RISC-V M corner-case rules.
  function automatic logic [31:0] ref_result(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint r;
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = 0;
    case (op)
      OP_MUL:    r = sa * sb;
      OP_MULH:   r = (sa * sb) >>> 32;
      OP_MULHSU: r = (sa * ub) >>> 32;
      OP_MULHU:  begin p = 64'(ua) * 64'(ub); r = longint'(p >> 32); end
      OP_DIV:    r = (b == 0) ? -1 : (ovf ? sa : sa / sb);
      OP_DIVU:   r = (b == 0) ? -1 : ua / ub;
      OP_REM:    r = (b == 0) ? sa : (ovf ? 0 : sa % sb);
      OP_REMU:   r = (b == 0) ? ua : ua % ub;
      default:   r = 0;
    endcase
    p = r;
    return p[31:0];
  endfunction

  function automatic int ref_lat(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    if ((op & 8'hF0) != 0) begin
      if (b == 0) return 1;
      if (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
      return 33;
    end
`ifdef MDU_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(20));
      default: return $urandom;
    endcase
  endfunction

  // Called just after a rising edge with the unit idle; returns just after a rising edge.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    e.res = ref_result(op, a, b);
    e.lat = ref_lat(op, a, b);
    e.t   = cyc;
    e.op  = op;
    sb_q.push_back(e);
    bus.DD_mdu_valid_i = 1'b1;
    bus.DD_mdu_op_i    = op;
    bus.DD_rs1_data_i  = a;
    bus.DD_rs2_data_i  = b;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.E_mdu_stall_o) break;
      n++;
    end
    chk("stall_cycles", 64'(n), 64'(e.lat));
    @(posedge clk); #1;
    bus.DD_mdu_valid_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.E_mdu_valid_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got strobe result 0x%08h expected no strobe (cycle %0d)",
                 bus.E_mdu_result_o, cyc);
      end else begin
        m = sb_q.pop_front();
        $display("[%0d] op=%08b result=0x%08h expected=0x%08h latency=%0d",
                 cyc, m.op, bus.E_mdu_result_o, m.res, cyc - m.t);
        chk("result", 64'(bus.E_mdu_result_o), 64'(m.res));
        chk("latency", 64'(cyc - m.t), 64'(m.lat));
      end
    end else begin
      chk("result_zero_when_idle", 64'(bus.E_mdu_result_o), 64'h0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.DD_mdu_valid_i = 1'b0;
    bus.DD_mdu_op_i    = 8'h0;
    bus.DD_rs1_data_i  = 32'h0;
    bus.DD_rs2_data_i  = 32'h0;
    bus.flush_i        = 1'b0;

    // Reset state, with a pending instruction presented.
    repeat (2) @(posedge clk);
    #1;
    bus.DD_mdu_valid_i = 1'b1;
    bus.DD_mdu_op_i    = OP_DIV;
    #1;
    chk("reset_stall", 64'(bus.E_mdu_stall_o), 64'h0);
    chk("reset_valid", 64'(bus.E_mdu_valid_o), 64'h0);
    chk("reset_result", 64'(bus.E_mdu_result_o), 64'h0);
    bus.DD_mdu_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases.
    run_op(OP_DIV,  32'd100, 32'd7);
    run_op(OP_REM,  32'd100, 32'd7);
    run_op(OP_DIVU, 32'h1234, 32'h0);
    run_op(OP_REMU, 32'h1234, 32'h0);
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_MULHSU, 32'hFFFF_FFFE, 32'h8000_0001);
    run_op(OP_DIV,  32'hFFFF_FF9C, 32'd7);
    run_op(OP_REM,  32'hFFFF_FF9C, 32'd7);

    // Flush at CALC cycle 10 (T+11): no strobe, stall released that cycle.
    bus.DD_mdu_valid_i = 1'b1;
    bus.DD_mdu_op_i    = OP_DIV;
    bus.DD_rs1_data_i  = 32'h7FFF_FFFF;
    bus.DD_rs2_data_i  = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    #1;
    chk("flush_stall", 64'(bus.E_mdu_stall_o), 64'h0);
    chk("flush_valid", 64'(bus.E_mdu_valid_o), 64'h0);
    @(posedge clk); #1;
    bus.flush_i        = 1'b0;
    bus.DD_mdu_valid_i = 1'b0;
    run_op(OP_DIVU, 32'd10, 32'd3);

    // Reset at CALC cycle 5 (T+6): outputs drop at once, no later strobe.
    bus.DD_mdu_valid_i = 1'b1;
    bus.DD_mdu_op_i    = OP_DIV;
    bus.DD_rs1_data_i  = 32'd1000;
    bus.DD_rs2_data_i  = 32'd9;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midcalc_reset_stall", 64'(bus.E_mdu_stall_o), 64'h0);
    chk("midcalc_reset_valid", 64'(bus.E_mdu_valid_o), 64'h0);
    chk("midcalc_reset_result", 64'(bus.E_mdu_result_o), 64'h0);
    bus.DD_mdu_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    run_op(OP_REMU, 32'd10, 32'd3);

    // Randomized mix over all eight ops.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] op;
      op = 8'h1 << $urandom_range(7);
      run_op(op, pick_operand(), pick_operand());
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
